pc_sequencer: RTL and testbench

Next-PC controller for the fetch stage of the single-issue MIPS core. Each cycle it decides whether the program counter register advances and what it loads: sequential PC+4, a branch target, a jump target or (optionally) the exception vector. Redirects that arrive while fetch is stalled are held pending, and a halt freezes the PC. It drives the PC register's load-enable and next-value inputs and generates the fetch flush.

---
 rtl/pc_sequencer.sv | 97 +++++++++
 tb/tb_pc_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the fetch stage (sequential, branch, jump, optional exception redirect)
// Ports: CLK/RST clock and sync active-high reset; pc/npc current PC and PC+4;
//        ihit/stall/halt fetch and pipeline control; br_taken/br_target, jmp/jmp_target redirects;
//        PCen/cpc PC register load enable and value; flush wrong-path kill; halted core frozen.
// Optional feature macro PC_EXCEPTION_EN adds exc input, epc output and the EXC_VECTOR redirect.
module pc_sequencer #(
    parameter int                WORD_W     = 32,
    parameter logic [WORD_W-1:0] EXC_VECTOR = 'h0000_0080
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] npc,
    input  logic              ihit,
    input  logic              stall,
    input  logic              halt,
    input  logic              br_taken,
    input  logic [WORD_W-1:0] br_target,
    input  logic              jmp,
    input  logic [WORD_W-1:0] jmp_target,
    output logic              PCen,
    output logic [WORD_W-1:0] cpc,
    output logic              flush,
    output logic              halted
`ifdef PC_EXCEPTION_EN
    ,
    input  logic              exc,
    output logic [WORD_W-1:0] epc
`endif
);
    typedef enum logic [1:0] {RUN, PEND, HALT} state_t;
    state_t            state, state_nx;
    logic [WORD_W-1:0] pend_tgt, pend_nx, redir, cpc_raw;
    logic              advance, redir_v, exc_v;
`ifdef PC_EXCEPTION_EN
    assign exc_v   = exc;
    assign redir_v = exc | br_taken | jmp;
    assign redir   = exc ? EXC_VECTOR : br_taken ? br_target : jmp_target;
`else
    assign exc_v   = 1'b0;
    assign redir_v = br_taken | jmp;
    assign redir   = br_taken ? br_target : jmp_target;
`endif
    assign advance = ihit & ~stall & ~RST & (state != HALT);
    assign halted  = state == HALT;
    assign cpc     = cpc_raw & ~WORD_W'(3);
    always_comb begin
        state_nx = state;
        pend_nx  = pend_tgt;
        PCen     = 1'b0;
        flush    = 1'b0;
        cpc_raw  = pc;
        if (!RST && state != HALT) begin
            if (halt) begin
                state_nx = HALT;
            end else if (state == RUN) begin
                if (redir_v && advance) begin
                    PCen    = 1'b1;
                    flush   = 1'b1;
                    cpc_raw = redir;
                end else if (redir_v) begin
                    pend_nx  = redir;
                    state_nx = PEND;
                end else begin
                    PCen    = advance;
                    cpc_raw = advance ? npc : pc;
                end
            end else begin
                // Only an exception may replace a latched target; it also wins this cycle's load.
                pend_nx = exc_v ? EXC_VECTOR : pend_tgt;
                if (advance) begin
                    PCen     = 1'b1;
                    flush    = 1'b1;
                    cpc_raw  = pend_nx;
                    state_nx = RUN;
                end
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= RUN;
            pend_tgt <= '0;
        end else begin
            state    <= state_nx;
            pend_tgt <= pend_nx;
        end
    end
`ifdef PC_EXCEPTION_EN
    always_ff @(posedge CLK) begin
        if (RST)
            epc <= '0;
        else if (exc && !halt && state != HALT)
            epc <= pc;
    end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven, hand-sequenced and randomized model checks of pc_sequencer
module tb_pc_sequencer;
    localparam logic [31:0] EXC_V = 32'h80;
`ifdef PC_EXCEPTION_EN
    localparam bit EXC_EN = 1'b1;
    logic [31:0] epc;
    logic [31:0] m_epc;
`else
    localparam bit EXC_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst, ihit, stall, halt, br, jmp, exc;
    logic [31:0] pc, npc, bt, jt, cpc;
    logic        pcen, flush, halted;
    int          checks = 0, fails = 0;

    pc_sequencer #(.WORD_W(32), .EXC_VECTOR(EXC_V)) dut (
        .CLK(clk), .RST(rst), .pc(pc), .npc(npc), .ihit(ihit), .stall(stall), .halt(halt),
        .br_taken(br), .br_target(bt), .jmp(jmp), .jmp_target(jt),
        .PCen(pcen), .cpc(cpc), .flush(flush), .halted(halted)
`ifdef PC_EXCEPTION_EN
        , .exc(exc), .epc(epc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst, ihit, stall, halt, br, jmp;
        logic [31:0] pc, npc, bt, jt;
        int          reps;
        bit          e_pcen, e_flush, e_halted;
        logic [31:0] e_cpc;
    } vec_t;
    vec_t vec [17];

    bit          m_halt, m_pend;
    logic [31:0] m_tgt;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(bit r, bit ih, bit st, bit hl, bit b, bit j, bit ex,
                          logic [31:0] p, logic [31:0] np, logic [31:0] btg, logic [31:0] jtg);
        rst = r; ihit = ih; stall = st; halt = hl; br = b; jmp = j; exc = ex;
        pc = p; npc = np; bt = btg; jt = jtg;
    endtask

    task automatic chk_out(string tag, bit e_pcen, logic [31:0] e_cpc, bit e_flush);
        chk({tag, " PCen"}, {31'b0, pcen}, {31'b0, e_pcen});
        chk({tag, " cpc"}, cpc, e_cpc);
        chk({tag, " flush"}, {31'b0, flush}, {31'b0, e_flush});
    endtask

    // Reference: pending redirect is a flag plus target; halt is a sticky flag cleared by reset.
    task automatic model_step(output bit e_pcen, output logic [31:0] e_cpc, output bit e_flush);
        bit          ex, adv, rv;
        logic [31:0] r;
        ex  = exc && EXC_EN;
        adv = ihit && !stall && !rst && !m_halt;
        rv  = ex || br || jmp;
        r   = ex ? EXC_V : (br ? bt : jt);
        e_pcen = 1'b0; e_flush = 1'b0; e_cpc = pc;
        if (rst) begin
            m_halt = 1'b0; m_pend = 1'b0; m_tgt = 32'h0;
`ifdef PC_EXCEPTION_EN
            m_epc = 32'h0;
`endif
        end else if (!m_halt && halt) begin
            m_halt = 1'b1;
        end else if (!m_halt) begin
`ifdef PC_EXCEPTION_EN
            if (ex) m_epc = pc;
`endif
            if (m_pend) begin
                if (ex) m_tgt = EXC_V;
                if (adv) begin
                    e_pcen = 1'b1; e_flush = 1'b1; e_cpc = m_tgt; m_pend = 1'b0;
                end
            end else if (rv && adv) begin
                e_pcen = 1'b1; e_flush = 1'b1; e_cpc = r;
            end else if (rv) begin
                m_pend = 1'b1; m_tgt = r;
            end else if (adv) begin
                e_pcen = 1'b1; e_cpc = npc;
            end
        end
        e_cpc = {e_cpc[31:2], 2'b00};
    endtask

    initial begin
        logic [31:0] p;
        vec[0]  = '{'0,'1,'0,'0,'1,'0, 32'h40, 32'h44, 32'h100, 32'h0, 1, '1,'1,'0, 32'h100};
        vec[1]  = '{'0,'1,'0,'0,'0,'0, 32'h100, 32'h104, 32'h0, 32'h0, 1, '1,'0,'0, 32'h104};
        vec[2]  = '{'0,'0,'0,'0,'1,'0, 32'h104, 32'h108, 32'h200, 32'h0, 1, '0,'0,'0, 32'h104};
        vec[3]  = '{'0,'0,'0,'0,'0,'0, 32'h104, 32'h108, 32'h0, 32'h0, 1, '0,'0,'0, 32'h104};
        vec[4]  = '{'0,'0,'0,'0,'0,'1, 32'h104, 32'h108, 32'h0, 32'h500, 1, '0,'0,'0, 32'h104};
        vec[5]  = '{'0,'1,'0,'0,'0,'0, 32'h104, 32'h108, 32'h0, 32'h0, 1, '1,'1,'0, 32'h200};
        vec[6]  = '{'0,'1,'0,'0,'1,'1, 32'h200, 32'h204, 32'h300, 32'h400, 1, '1,'1,'0, 32'h300};
        vec[7]  = '{'0,'1,'0,'0,'0,'1, 32'h300, 32'h304, 32'h0, 32'h403, 1, '1,'1,'0, 32'h400};
        vec[8]  = '{'0,'1,'1,'0,'0,'1, 32'h400, 32'h404, 32'h0, 32'h600, 1, '0,'0,'0, 32'h400};
        vec[9]  = '{'0,'1,'0,'0,'0,'0, 32'h400, 32'h404, 32'h0, 32'h0, 1, '1,'1,'0, 32'h600};
        vec[10] = '{'0,'1,'0,'1,'1,'0, 32'h600, 32'h604, 32'h700, 32'h0, 1, '0,'0,'0, 32'h600};
        vec[11] = '{'0,'1,'0,'0,'1,'0, 32'h600, 32'h604, 32'h700, 32'h0, 10, '0,'0,'1, 32'h600};
        vec[12] = '{'1,'1,'0,'0,'1,'0, 32'h600, 32'h604, 32'h700, 32'h0, 1, '0,'0,'1, 32'h600};
        vec[13] = '{'0,'1,'0,'0,'0,'0, 32'h600, 32'h604, 32'h0, 32'h0, 1, '1,'0,'0, 32'h604};
        vec[14] = '{'0,'1,'0,'0,'0,'0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 1, '1,'0,'0, 32'h0};
        vec[15] = '{'0,'1,'0,'0,'0,'0, 32'h0, 32'h7, 32'h0, 32'h0, 1, '1,'0,'0, 32'h4};
        vec[16] = '{'0,'0,'0,'0,'0,'0, 32'h13, 32'h17, 32'h0, 32'h0, 1, '0,'0,'0, 32'h10};
        set_in('1,'1,'0,'0,'0,'0,'0, 32'h0, 32'h4, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            chk_out($sformatf("reset%0d", i), 1'b0, 32'h0, 1'b0);
        end
        chk("reset halted", {31'b0, halted}, 32'h0);
        p = 32'h0;
        for (int i = 0; i < 8; i++) begin
            tick();
            set_in('0,'1,'0,'0,'0,'0,'0, p, p + 32'h4, 32'h0, 32'h0);
            @(negedge clk);
            chk_out($sformatf("seq%0d", i), 1'b1, p + 32'h4, 1'b0);
            p = p + 32'h4;
        end
        for (int i = 0; i < 17; i++) begin
            for (int r = 0; r < vec[i].reps; r++) begin
                tick();
                set_in(vec[i].rst, vec[i].ihit, vec[i].stall, vec[i].halt, vec[i].br, vec[i].jmp, '0,
                       vec[i].pc, vec[i].npc, vec[i].bt, vec[i].jt);
                @(negedge clk);
                chk_out($sformatf("vec%0d.%0d", i, r), vec[i].e_pcen, vec[i].e_cpc, vec[i].e_flush);
                chk($sformatf("vec%0d.%0d halted", i, r), {31'b0, halted}, {31'b0, vec[i].e_halted});
            end
        end
`ifdef PC_EXCEPTION_EN
        tick(); set_in('1,'0,'0,'0,'0,'0,'0, 32'h0, 32'h4, 32'h0, 32'h0);
        tick(); set_in('0,'0,'0,'0,'1,'0,'0, 32'h104, 32'h108, 32'h200, 32'h0);
        @(negedge clk); chk_out("exc latch br", 1'b0, 32'h104, 1'b0);
        tick(); set_in('0,'0,'0,'0,'0,'0,'1, 32'h88, 32'h8c, 32'h0, 32'h0);
        @(negedge clk); chk_out("exc in pend", 1'b0, 32'h88, 1'b0);
        tick(); set_in('0,'1,'0,'0,'0,'0,'0, 32'h88, 32'h8c, 32'h0, 32'h0);
        @(negedge clk); chk_out("exc apply", 1'b1, 32'h80, 1'b1);
        chk("exc epc", epc, 32'h88);
        tick(); set_in('0,'1,'0,'0,'0,'0,'0, 32'h80, 32'h84, 32'h0, 32'h0);
        @(negedge clk); chk_out("exc after", 1'b1, 32'h84, 1'b0);
`endif
        tick();
        set_in('1,'0,'0,'0,'0,'0,'0, 32'h0, 32'h4, 32'h0, 32'h0);
        begin
            bit          ep, ef, old_h;
            logic [31:0] ec;
            model_step(ep, ec, ef);
        end
        for (int i = 0; i < 400; i++) begin
            bit          ep, ef, old_h;
            logic [31:0] ec, r32;
`ifdef PC_EXCEPTION_EN
            logic [31:0] old_epc;
`endif
            tick();
            r32 = $urandom;
            set_in(($urandom % 40) == 0, ($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 50) == 0,
                   ($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                   r32, r32 + 32'h4, $urandom, $urandom);
            @(negedge clk);
            old_h = m_halt;
`ifdef PC_EXCEPTION_EN
            old_epc = m_epc;
            chk($sformatf("rnd%0d epc", i), epc, old_epc);
`endif
            model_step(ep, ec, ef);
            chk_out($sformatf("rnd%0d", i), ep, ec, ef);
            chk($sformatf("rnd%0d halted", i), {31'b0, halted}, {31'b0, old_h});
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
